fft_seq_ctrl: RTL and testbench

FFT_SEQ_CTRL -- requirements
Module: fft_seq_ctrl

---
 rtl/fft_pkg.sv | 21 ++
 rtl/fft_bitrev.sv | 21 ++
 rtl/fft_seq_ctrl.sv | 177 +++++++++++++++++
 tb/tb_fft_seq_ctrl.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared types and size limits for the FFT sequencing controller.
// Enum for the controller FSM plus default counter widths.
package fft_pkg;

   localparam int FFT_MIN_LOG2N = 3;
   localparam int FFT_MAX_LOG2N = 10;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_COMPUTE,
      S_READ,
      S_DONE
   } fft_state_e;

   typedef logic [FFT_MAX_LOG2N-1:0]         fft_addr_t;
   typedef logic [FFT_MAX_LOG2N-2:0]         fft_bidx_t;
   typedef logic [$clog2(FFT_MAX_LOG2N)-1:0] fft_stage_t;
   typedef logic [$clog2(FFT_MAX_LOG2N+1)-1:0] fft_len_t;

endpackage

// File: rtl/fft_bitrev.sv
// Reverses the low len_i bits of in_i; bits at or above len_i read as zero.
// Used to scatter input samples into bit-reversed memory order.
module fft_bitrev #(
   parameter int W  = 10,
   parameter int LW = 4
) (
   input  logic [W-1:0]  in_i,
   input  logic [LW-1:0] len_i,
   output logic [W-1:0]  out_o
);

   always_comb begin
      out_o = '0;
      for (int i = 0; i < W; i++) begin
         for (int j = 0; j < W; j++) begin
            if (i + j + 1 == int'(len_i)) out_o[i] = in_i[j];
         end
      end
   end

endmodule

// File: rtl/fft_seq_ctrl.sv
// Sequencer for an in-place radix-2 FFT: load, butterfly issue, read-out.
// Addresses and indices are driven only in their own phase, zero otherwise.
module fft_seq_ctrl
   import fft_pkg::*;
#(
   parameter int MAX_LOG2N = FFT_MAX_LOG2N,
   parameter int MIN_LOG2N = FFT_MIN_LOG2N
) (
   input  logic                           clk_i,
   input  logic                           rst_ni,
   input  logic                           start_i,
   input  logic [$clog2(MAX_LOG2N+1)-1:0] log2n_i,
   input  logic                           abort_i,
   input  logic                           sample_valid_i,
   input  logic                           bfly_ready_i,
   input  logic                           rd_ready_i,
   output logic                           wr_mem_o,
   output logic [MAX_LOG2N-1:0]           wr_addr_o,
   output logic                           bfly_valid_o,
   output logic [$clog2(MAX_LOG2N)-1:0]   stage_o,
   output logic [MAX_LOG2N-2:0]           bfly_idx_o,
   output logic                           rd_en_o,
   output logic [MAX_LOG2N-1:0]           rd_addr_o,
   output logic                           done_o,
   output logic                           busy_o,
   output logic                           err_o
);

   localparam int AW = MAX_LOG2N;
   localparam int IW = MAX_LOG2N - 1;
   localparam int SW = $clog2(MAX_LOG2N);
   localparam int LW = $clog2(MAX_LOG2N + 1);

   fft_state_e    state_q, state_d;
   logic [LW-1:0] len_q;
   logic [AW-1:0] samp_cnt_q;
   logic [AW-1:0] rd_cnt_q;
   logic [IW-1:0] idx_q;
   logic [SW-1:0] stage_q;
   logic          err_q;

   logic          start_ok, err_d, clr;
   logic          ld_fire, iss_fire, rd_fire;
   logic          in_range, last_stage;
   logic [AW-1:0] n_m1;
   logic [IW-1:0] half_m1;
   logic [AW-1:0] rev_addr;

   // Shifting by len_q == AW yields zero, so n_m1 becomes all ones.
   assign n_m1       = ~({AW{1'b1}} << len_q);
   assign half_m1    = n_m1[AW-1:1];
   assign last_stage = (int'(stage_q) + 1 == int'(len_q));
   assign in_range   = (int'(log2n_i) >= MIN_LOG2N)
                    && (int'(log2n_i) <= MAX_LOG2N);
   assign err_o      = err_q;

   fft_bitrev #(
      .W  (AW),
      .LW (LW)
   ) u_bitrev (
      .in_i  (samp_cnt_q),
      .len_i (len_q),
      .out_o (rev_addr)
   );

   always_comb begin
      state_d      = state_q;
      start_ok     = 1'b0;
      err_d        = 1'b0;
      clr          = 1'b0;
      ld_fire      = 1'b0;
      iss_fire     = 1'b0;
      rd_fire      = 1'b0;
      wr_mem_o     = 1'b0;
      wr_addr_o    = '0;
      bfly_valid_o = 1'b0;
      stage_o      = '0;
      bfly_idx_o   = '0;
      rd_en_o      = 1'b0;
      rd_addr_o    = '0;
      done_o       = 1'b0;
      busy_o       = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               if (in_range) begin
                  start_ok = 1'b1;
                  clr      = 1'b1;
                  state_d  = S_LOAD;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         S_LOAD: begin
            busy_o    = 1'b1;
            wr_mem_o  = sample_valid_i;
            wr_addr_o = rev_addr;
            ld_fire   = sample_valid_i;
            if (ld_fire && samp_cnt_q == n_m1) state_d = S_COMPUTE;
         end
         S_COMPUTE: begin
            busy_o       = 1'b1;
            bfly_valid_o = 1'b1;
            stage_o      = stage_q;
            bfly_idx_o   = idx_q;
            iss_fire     = bfly_ready_i;
            if (iss_fire && last_stage && idx_q == half_m1)
               state_d = S_READ;
         end
         S_READ: begin
            busy_o    = 1'b1;
            rd_en_o   = 1'b1;
            rd_addr_o = rd_cnt_q;
            rd_fire   = rd_ready_i;
            if (rd_fire && rd_cnt_q == n_m1) state_d = S_DONE;
         end
         S_DONE: begin
            done_o  = 1'b1;
            clr     = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      // Abort overrides every other event, including the done pulse.
      if (abort_i) begin
         state_d  = S_IDLE;
         clr      = 1'b1;
         start_ok = 1'b0;
         err_d    = 1'b0;
         ld_fire  = 1'b0;
         iss_fire = 1'b0;
         rd_fire  = 1'b0;
         done_o   = 1'b0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= S_IDLE;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         err_q   <= err_d;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         len_q      <= LW'(MIN_LOG2N);
         samp_cnt_q <= '0;
         rd_cnt_q   <= '0;
         idx_q      <= '0;
         stage_q    <= '0;
      end else begin
         if (start_ok) len_q <= log2n_i;
         if (clr) begin
            samp_cnt_q <= '0;
            rd_cnt_q   <= '0;
            idx_q      <= '0;
            stage_q    <= '0;
         end else begin
            if (ld_fire) samp_cnt_q <= samp_cnt_q + 1'b1;
            if (iss_fire) begin
               if (idx_q == half_m1) begin
                  idx_q   <= '0;
                  stage_q <= stage_q + 1'b1;
               end else begin
                  idx_q <= idx_q + 1'b1;
               end
            end
            if (rd_fire) rd_cnt_q <= rd_cnt_q + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_fft_seq_ctrl.sv
// Directed bench for fft_seq_ctrl: full runs, size errors, stalls,
// abort, mid-read reset and load gaps, checked against hand values.
module tb_fft_seq_ctrl;

   logic       clk_i = 1'b0;
   logic       rst_ni;
   logic       start_i;
   logic [3:0] log2n_i;
   logic       abort_i;
   logic       sample_valid_i;
   logic       bfly_ready_i;
   logic       rd_ready_i;
   logic       wr_mem_o;
   logic [9:0] wr_addr_o;
   logic       bfly_valid_o;
   logic [3:0] stage_o;
   logic [8:0] bfly_idx_o;
   logic       rd_en_o;
   logic [9:0] rd_addr_o;
   logic       done_o;
   logic       busy_o;
   logic       err_o;
   logic [38:0] outs;

   int total = 0;
   int bad   = 0;
   int tbl3[8] = '{0, 4, 2, 6, 1, 5, 3, 7};

   always #5 clk_i = ~clk_i;

   assign outs = {wr_mem_o, wr_addr_o, bfly_valid_o, stage_o, bfly_idx_o,
                  rd_en_o, rd_addr_o, done_o, busy_o, err_o};

   fft_seq_ctrl dut (
      .clk_i          (clk_i),
      .rst_ni         (rst_ni),
      .start_i        (start_i),
      .log2n_i        (log2n_i),
      .abort_i        (abort_i),
      .sample_valid_i (sample_valid_i),
      .bfly_ready_i   (bfly_ready_i),
      .rd_ready_i     (rd_ready_i),
      .wr_mem_o       (wr_mem_o),
      .wr_addr_o      (wr_addr_o),
      .bfly_valid_o   (bfly_valid_o),
      .stage_o        (stage_o),
      .bfly_idx_o     (bfly_idx_o),
      .rd_en_o        (rd_en_o),
      .rd_addr_o      (rd_addr_o),
      .done_o         (done_o),
      .busy_o         (busy_o),
      .err_o          (err_o)
   );

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   function automatic int exp_rev(input int k, input int l);
      int r;
      if (l == 3) return tbl3[k];
      r = 0;
      for (int b = 0; b < l; b++)
         if (((k >> b) & 1) == 1) r = r + (1 << (l - 1 - b));
      return r;
   endfunction

   // mode: 0 normal, 1 abort in stage 1, 2 reset during read
   task automatic run(input int l, input bit gaps, input bit tog,
                      input int mode);
      int n, k, s, i, iss, cyc;
      bit sv, rdy;
      n = 1 << l;
      start_i = 1'b1;
      log2n_i = 4'(l);
      @(negedge clk_i);
      chk("idle_busy", 64'(busy_o), 64'd0);
      step();
      start_i = 1'b0;
      k = 0;
      cyc = 0;
      while (k < n && cyc < 4 * n) begin
         sv = gaps ? (cyc % 3 != 2) : 1'b1;
         sample_valid_i = sv;
         start_i = gaps;
         log2n_i = 4'd5;
         @(negedge clk_i);
         chk("ld_wr", 64'(wr_mem_o), 64'(sv));
         chk("ld_busy", 64'(busy_o), 64'd1);
         if (sv) chk("ld_addr", 64'(wr_addr_o), 64'(exp_rev(k, l)));
         step();
         if (sv) k++;
         cyc++;
      end
      sample_valid_i = 1'b0;
      start_i = 1'b0;
      s = 0;
      i = 0;
      iss = 0;
      cyc = 0;
      while (iss < l * n / 2 && cyc < 4 * l * n) begin
         rdy = tog ? (cyc % 2 == 1) : 1'b1;
         bfly_ready_i = rdy;
         if (mode == 1 && s == 1 && i == 1) abort_i = 1'b1;
         @(negedge clk_i);
         chk("cp_valid", 64'(bfly_valid_o), 64'd1);
         chk("cp_stage", 64'(stage_o), 64'(s));
         chk("cp_idx", 64'(bfly_idx_o), 64'(i));
         step();
         if (abort_i) begin
            abort_i = 1'b0;
            bfly_ready_i = 1'b0;
            @(negedge clk_i);
            chk("ab_outs", 64'(outs), 64'd0);
            step();
            @(negedge clk_i);
            chk("ab_outs2", 64'(outs), 64'd0);
            step();
            return;
         end
         if (rdy) begin
            iss++;
            if (i == n / 2 - 1) begin
               i = 0;
               s++;
            end else begin
               i++;
            end
         end
         cyc++;
      end
      bfly_ready_i = 1'b0;
      for (int j = 0; j < n; j++) begin
         rd_ready_i = 1'b1;
         if (mode == 2 && j == 3) begin
            rst_ni = 1'b0;
            #1;
            chk("rst_outs", 64'(outs), 64'd0);
            @(negedge clk_i);
            chk("rst_outs2", 64'(outs), 64'd0);
            step();
            rst_ni = 1'b1;
            rd_ready_i = 1'b0;
            return;
         end
         @(negedge clk_i);
         if (j == 0) chk("cp_end", 64'(bfly_valid_o), 64'd0);
         chk("rd_en", 64'(rd_en_o), 64'd1);
         chk("rd_addr", 64'(rd_addr_o), 64'(j));
         step();
      end
      rd_ready_i = 1'b0;
      @(negedge clk_i);
      chk("done_hi", 64'(done_o), 64'd1);
      chk("done_busy", 64'(busy_o), 64'd0);
      step();
      @(negedge clk_i);
      chk("done_lo", 64'(outs), 64'd0);
      step();
   endtask

   task automatic bad_size(input int l);
      start_i = 1'b1;
      log2n_i = 4'(l);
      @(negedge clk_i);
      chk("err_pre", 64'(err_o), 64'd0);
      step();
      start_i = 1'b0;
      @(negedge clk_i);
      chk("err_hi", 64'(err_o), 64'd1);
      chk("err_busy", 64'(busy_o), 64'd0);
      step();
      @(negedge clk_i);
      chk("err_lo", 64'(err_o), 64'd0);
      chk("err_busy2", 64'(busy_o), 64'd0);
      step();
   endtask

   initial begin
      rst_ni = 1'b0;
      start_i = 1'b0;
      log2n_i = 4'd0;
      abort_i = 1'b0;
      sample_valid_i = 1'b0;
      bfly_ready_i = 1'b0;
      rd_ready_i = 1'b0;
      #2;
      chk("reset_outs", 64'(outs), 64'd0);
      step();
      step();
      rst_ni = 1'b1;
      @(negedge clk_i);
      chk("post_reset", 64'(outs), 64'd0);
      step();
      run(3, 1'b0, 1'b0, 0);
      bad_size(2);
      bad_size(11);
      run(4, 1'b0, 1'b1, 0);
      run(3, 1'b0, 1'b0, 1);
      run(3, 1'b0, 1'b0, 0);
      run(3, 1'b0, 1'b0, 2);
      run(3, 1'b0, 1'b0, 0);
      run(3, 1'b1, 1'b0, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
